// File: rtl/fetch_pc_stage_pkg.sv
// Shared encodings for the MIPS fetch stage: next-PC selects, exception codes, reset PC.
package fetch_pc_stage_pkg;
  localparam logic [1:0]  NPC_PC4 = 2'b00;
  localparam logic [1:0]  NPC_BR  = 2'b01;
  localparam logic [1:0]  NPC_J   = 2'b10;
  localparam logic [1:0]  NPC_JR  = 2'b11;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
endpackage

// File: rtl/fetch_npc_calc.sv
// Combinational next-PC: sequential, branch, jump and register-jump targets plus select.
module fetch_npc_calc
  import fetch_pc_stage_pkg::*;
(
  input  logic [31:0] f_pc_i,
  input  logic [31:0] d_pc_i,
  input  logic [1:0]  npc_sel_i,
  input  logic        br_taken_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] index26_i,
  input  logic [31:0] rs_val_i,
  output logic [31:0] npc_o
);
  logic [31:0] pc4, br_tgt, j_tgt;

  assign pc4    = f_pc_i + 32'd4;
  // Targets are relative to the delay-slot PC, which is D_pc + 4.
  assign br_tgt = d_pc_i + 32'd4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
  assign j_tgt  = {d_pc_i[31:28], index26_i, 2'b00};

  always_comb begin
    npc_o = pc4;
    case (npc_sel_i)
      NPC_BR:  npc_o = br_taken_i ? br_tgt : pc4;
      NPC_J:   npc_o = j_tgt;
      NPC_JR:  npc_o = rs_val_i;
      default: npc_o = pc4;
    endcase
  end
endmodule

// File: rtl/fetch_pc_stage.sv
// MIPS F-stage: PC register, next-PC select and F/D pipeline register.
// FETCH_EXC_EN enables address-error (AdEL) detection on the fetch address.
module fetch_pc_stage
  import fetch_pc_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_index26,
  input  logic [31:0] D_rs_val,
  input  logic [31:0] F_instr,
  output logic [31:0] F_pc,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc8,
  output logic [4:0]  D_exc_code
);
  logic [31:0] f_pc_q, d_pc_q, d_instr_q, npc;
  logic [31:0] fetch_instr;
  logic [4:0]  fetch_code;

  fetch_npc_calc u_npc (
    .f_pc_i    (f_pc_q),
    .d_pc_i    (d_pc_q),
    .npc_sel_i (npc_sel),
    .br_taken_i(br_taken),
    .imm16_i   (D_imm16),
    .index26_i (D_index26),
    .rs_val_i  (D_rs_val),
    .npc_o     (npc)
  );

`ifdef FETCH_EXC_EN
  logic       fetch_exc;
  logic [4:0] d_exc_q;

  assign fetch_exc   = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_BASE) || (f_pc_q > IM_LIMIT);
  assign fetch_code  = fetch_exc ? EXC_ADEL : EXC_NONE;
  // A faulting fetch must not deliver its (bogus) word downstream.
  assign fetch_instr = fetch_exc ? 32'd0 : F_instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      d_exc_q <= EXC_NONE;
    else if (flush) d_exc_q <= EXC_NONE;
    else if (!stall) d_exc_q <= fetch_code;
  end
  assign D_exc_code = d_exc_q;
`else
  logic unused_im;
  assign unused_im   = ^{IM_BASE, IM_LIMIT};
  assign fetch_code  = EXC_NONE;
  assign fetch_instr = F_instr;
  assign D_exc_code  = fetch_code;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       f_pc_q <= PC_RESET;
    else if (!stall) f_pc_q <= npc;
  end

  // Flush wins over stall so a bubble can be injected while F is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_pc_q    <= PC_RESET;
      d_instr_q <= 32'd0;
    end else if (flush) begin
      d_pc_q    <= f_pc_q;
      d_instr_q <= 32'd0;
    end else if (!stall) begin
      d_pc_q    <= f_pc_q;
      d_instr_q <= fetch_instr;
    end
  end

  assign F_pc    = f_pc_q;
  assign D_pc    = d_pc_q;
  assign D_instr = d_instr_q;
  assign D_pc8   = d_pc_q + 32'd8;
endmodule

// File: tb/tb_fetch_pc_stage.sv
// Scoreboard bench for fetch_pc_stage: stimulus pushes expected post-edge state, monitor compares.
module tb_fetch_pc_stage;
  import fetch_pc_stage_pkg::*;

  logic        clk, reset, stall, flush, br_taken;
  logic [1:0]  npc_sel;
  logic [15:0] D_imm16;
  logic [25:0] D_index26;
  logic [31:0] D_rs_val, F_instr, F_pc, D_pc, D_instr, D_pc8;
  logic [4:0]  D_exc_code;

  fetch_pc_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .npc_sel(npc_sel), .br_taken(br_taken), .D_imm16(D_imm16),
    .D_index26(D_index26), .D_rs_val(D_rs_val), .F_instr(F_instr),
    .F_pc(F_pc), .D_pc(D_pc), .D_instr(D_instr), .D_pc8(D_pc8),
    .D_exc_code(D_exc_code)
  );

  // Instruction memory model: word tagged with its own address.
  assign F_instr = {16'hC0DE, F_pc[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic [31:0] dinstr;
    logic [4:0]  exc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

`ifdef FETCH_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  task automatic chk_all(input string nm, input exp_t e);
    chk({nm, ".F_pc"},    F_pc,    e.fpc);
    chk({nm, ".D_pc"},    D_pc,    e.dpc);
    chk({nm, ".D_instr"}, D_instr, e.dinstr);
    chk({nm, ".D_pc8"},   D_pc8,   e.dpc + 32'd8);
    chk({nm, ".D_exc"},   {27'd0, D_exc_code}, {27'd0, e.exc});
  endtask

  // Monitor: state after each rising edge is compared against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) chk_all(name_q.pop_front(), exp_q.pop_front());
    end
  end

  task automatic cyc(input string nm, input logic [1:0] sel, input logic bt,
                     input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs,
                     input logic st, input logic fl,
                     input logic [31:0] efpc, input logic [31:0] edpc,
                     input logic [31:0] einstr, input logic [4:0] eexc);
    exp_t e;
    @(negedge clk);
    #1;
    npc_sel = sel; br_taken = bt; D_imm16 = imm; D_index26 = idx; D_rs_val = rs;
    stall = st; flush = fl;
    e.fpc = efpc; e.dpc = edpc; e.dinstr = einstr; e.exc = eexc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic seq(input string nm, input logic [31:0] efpc, input logic [31:0] edpc,
                     input logic [31:0] einstr, input logic [4:0] eexc);
    cyc(nm, NPC_PC4, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, efpc, edpc, einstr, eexc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    exp_t r;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; npc_sel = NPC_PC4; br_taken = 1'b0;
    D_imm16 = '0; D_index26 = '0; D_rs_val = '0;
    @(negedge clk); #1;
    r.fpc = 32'h3000; r.dpc = 32'h3000; r.dinstr = 32'h0; r.exc = EXC_NONE;
    chk_all("reset_state", r);
    @(negedge clk); #1;
    reset = 1'b0;
    r.fpc = 32'h3004; r.dpc = 32'h3000; r.dinstr = 32'hC0DE3000;
    exp_q.push_back(r); name_q.push_back("seq0");

    seq("seq1", 32'h3008, 32'h3004, 32'hC0DE3004, EXC_NONE);
    seq("seq2", 32'h300C, 32'h3008, 32'hC0DE3008, EXC_NONE);
    for (int i = 0; i < 3; i++)
      cyc("stall", NPC_PC4, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0,
          32'h300C, 32'h3008, 32'hC0DE3008, EXC_NONE);
    seq("stall_rel", 32'h3010, 32'h300C, 32'hC0DE300C, EXC_NONE);
    seq("seq3",      32'h3014, 32'h3010, 32'hC0DE3010, EXC_NONE);
    cyc("br_taken", NPC_BR, 1'b1, 16'hFFFC, 26'h0, 32'h0, 1'b0, 1'b0,
        32'h3004, 32'h3014, 32'hC0DE3014, EXC_NONE);
    cyc("br_not",   NPC_BR, 1'b0, 16'hFFFC, 26'h0, 32'h0, 1'b0, 1'b0,
        32'h3008, 32'h3004, 32'hC0DE3004, EXC_NONE);
    cyc("jr_301c",  NPC_JR, 1'b0, 16'h0, 26'h0, 32'h301C, 1'b0, 1'b0,
        32'h301C, 32'h3008, 32'hC0DE3008, EXC_NONE);
    seq("seq4", 32'h3020, 32'h301C, 32'hC0DE301C, EXC_NONE);
    seq("seq5", 32'h3024, 32'h3020, 32'hC0DE3020, EXC_NONE);
    cyc("jal",      NPC_J, 1'b0, 16'h0, 26'h0000C40, 32'h0, 1'b0, 1'b0,
        32'h3100, 32'h3024, 32'hC0DE3024, EXC_NONE);
    cyc("jr_3400",  NPC_JR, 1'b0, 16'h0, 26'h0, 32'h3400, 1'b0, 1'b0,
        32'h3400, 32'h3100, 32'hC0DE3100, EXC_NONE);
    seq("seq6", 32'h3404, 32'h3400, 32'hC0DE3400, EXC_NONE);
    cyc("stall_flush", NPC_JR, 1'b0, 16'h0, 26'h0, 32'h3500, 1'b1, 1'b1,
        32'h3404, 32'h3404, 32'h0, EXC_NONE);
    cyc("stall_redir", NPC_JR, 1'b0, 16'h0, 26'h0, 32'h3500, 1'b1, 1'b0,
        32'h3404, 32'h3404, 32'h0, EXC_NONE);
    cyc("redir_rel",   NPC_JR, 1'b0, 16'h0, 26'h0, 32'h3500, 1'b0, 1'b0,
        32'h3500, 32'h3404, 32'hC0DE3404, EXC_NONE);
    cyc("flush",       NPC_PC4, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1,
        32'h3504, 32'h3500, 32'h0, EXC_NONE);

    // Async reset pulse between edges while a jr redirect is being presented.
    @(negedge clk); #1;
    npc_sel = NPC_JR; D_rs_val = 32'h3600; flush = 1'b0; stall = 1'b0;
    #1 reset = 1'b1;
    #1;
    r.fpc = 32'h3000; r.dpc = 32'h3000; r.dinstr = 32'h0; r.exc = EXC_NONE;
    chk_all("async_reset", r);
    #1 reset = 1'b0;
    r.fpc = 32'h3600; r.dpc = 32'h3000; r.dinstr = 32'hC0DE3000;
    exp_q.push_back(r); name_q.push_back("post_reset_jr");

    cyc("jr_3002", NPC_JR, 1'b0, 16'h0, 26'h0, 32'h3002, 1'b0, 1'b0,
        32'h3002, 32'h3600, 32'hC0DE3600, EXC_NONE);
    seq("exc_mis0", 32'h3006, 32'h3002, EXC ? 32'h0 : 32'hC0DE3002, EXC ? EXC_ADEL : EXC_NONE);
    cyc("jr_7000", NPC_JR, 1'b0, 16'h0, 26'h0, 32'h7000, 1'b0, 1'b0,
        32'h7000, 32'h3006, EXC ? 32'h0 : 32'hC0DE3006, EXC ? EXC_ADEL : EXC_NONE);
    cyc("jr_back", NPC_JR, 1'b0, 16'h0, 26'h0, 32'h3000, 1'b0, 1'b0,
        32'h3000, 32'h7000, EXC ? 32'h0 : 32'hC0DE7000, EXC ? EXC_ADEL : EXC_NONE);
    seq("exc_clear", 32'h3004, 32'h3000, 32'hC0DE3000, EXC_NONE);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
